// File: rtl/branch_fwd_ctrl_pkg.sv
// branch_fwd_ctrl_pkg: select codes, shadow-stage type and producer match helper
package branch_fwd_ctrl_pkg;
  localparam int DEF_REG_AW = 5;
  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  typedef struct packed {
    logic v;
    logic rw;
    logic mr;
    logic [DEF_REG_AW-1:0] dst;
  } stage_t;
  function automatic logic hit(stage_t s, logic [DEF_REG_AW-1:0] r);
    return s.v & s.rw & (s.dst == r) & (|r);
  endfunction
endpackage

// File: rtl/branch_fwd_ctrl_if.sv
// branch_fwd_ctrl_if: ID-stage instruction fields in, comparator selects/stall/counter out
interface branch_fwd_ctrl_if #(parameter int REG_AW = 5, parameter int CNT_W = 16);
  logic id_valid;
  logic id_is_branch;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic id_regwrite;
  logic id_memread;
  logic [REG_AW-1:0] id_dst;
  logic [1:0] sel_rs;
  logic [1:0] sel_rt;
  logic stall;
  logic [CNT_W-1:0] stall_cnt;
  modport master(
    output id_valid, id_is_branch, id_rs, id_rt, id_regwrite, id_memread, id_dst,
    input sel_rs, sel_rt, stall, stall_cnt
  );
  modport slave(
    input id_valid, id_is_branch, id_rs, id_rt, id_regwrite, id_memread, id_dst,
    output sel_rs, sel_rt, stall, stall_cnt
  );
endinterface

// File: rtl/branch_fwd_decode.sv
// branch_fwd_decode: per-operand select and hazard from the EX/MEM/WB shadow stages
module branch_fwd_decode
  import branch_fwd_ctrl_pkg::*;
(
  input  logic [DEF_REG_AW-1:0] r,
  input  stage_t ex,
  input  stage_t mem,
  input  stage_t wb,
  output logic [1:0] sel,
  output logic hazard
);
  logic h_ex, h_mem, h_wb;
  assign h_ex = hit(ex, r);
  assign h_mem = hit(mem, r);
  assign h_wb = hit(wb, r);
  assign hazard = h_ex | (h_mem & mem.mr);
  assign sel = hazard ? SEL_RF : h_mem ? SEL_EXMEM : h_wb ? SEL_MEMWB : SEL_RF;
endmodule

// File: rtl/branch_fwd_ctrl.sv
// branch_fwd_ctrl: ID-stage branch comparator forwarding selects, stall and stall counter
module branch_fwd_ctrl
  import branch_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  branch_fwd_ctrl_if.slave bus
);
  stage_t ex, mem, wb, id;
  logic [REG_AW-1:0] rs, rt;
  logic [1:0] sel_rs, sel_rt;
  logic hz_rs, hz_rt, br, stall;
  logic [CNT_W-1:0] cnt;
  assign rs = bus.id_rs;
  assign rt = bus.id_rt;
  assign br = bus.id_valid & bus.id_is_branch;
  assign id = '{v: bus.id_valid, rw: bus.id_valid & bus.id_regwrite, mr: bus.id_memread, dst: bus.id_dst};
  branch_fwd_decode u_rs (.r(rs), .ex(ex), .mem(mem), .wb(wb), .sel(sel_rs), .hazard(hz_rs));
  branch_fwd_decode u_rt (.r(rt), .ex(ex), .mem(mem), .wb(wb), .sel(sel_rt), .hazard(hz_rt));
  assign stall = br & (hz_rs | hz_rt);
  assign bus.stall = stall;
  assign bus.sel_rs = br ? sel_rs : SEL_RF;
  assign bus.sel_rt = br ? sel_rt : SEL_RF;
  assign bus.stall_cnt = cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      cnt <= '0;
    end else begin
      wb <= mem;
      mem <= ex;
      ex <= stall ? '0 : id;
      if (stall && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: doc/branch_fwd_ctrl.md
Name: branch_fwd_ctrl

Overview:
- Controls the ID-stage branch comparator operand path of the 5-stage MIPS pipeline. Branch resolution sits in ID.
- Keeps its own shadow of the EX, MEM and WB stage destination registers.
- Each cycle it drives the two 2-bit select lines of the rs/rt comparator forwarding muxes and issues the ID-stage stall.
- Also keeps a saturating count of branch-induced stall cycles for performance reporting.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_is_branch  in  1  ID instruction is beq/bne; compares rs and rt.
- id_rs  in  REG_AW  ID source register 1.
- id_rt  in  REG_AW  ID source register 2.
- id_regwrite  in  1  ID instruction will write a register.
- id_memread  in  1  ID instruction is a load.
- id_dst  in  REG_AW  ID destination register, already resolved rd/rt.
- sel_rs  out  2  select for the rs comparator mux.
- sel_rt  out  2  select for the rt comparator mux.
- stall  out  1  hold PC and IF/ID; inject a bubble into ID/EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding, fixed by the comparator mux:
  - 00 = register-file value.
  - 01 = MEM/WB value.
  - 10 = EX/MEM value.
  - 11 is never driven, because the mux outputs 0 for it.
- Shadow state per stage S in {EX, MEM, WB}: s_v, s_rw, s_mr, s_dst.
- Advance on every rising clk:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields when stall=0.
  - EX <= bubble (v=0) when stall=1.
- Field meanings: s_v is id_valid; s_rw is id_valid & id_regwrite; s_mr is id_memread.
- Producer match for operand r in stage S: S.v & S.rw & (S.dst == r) & (r != 0). Register 0 never matches.
- Outputs are combinational from the registered shadow plus current ID inputs (zero latency, Moore-plus-ID). When id_valid & id_is_branch = 0: sel_rs = sel_rt = 00 and stall = 0.
- For a valid branch, per operand r:
  - EX match -> hazard (value not yet computed); sel 00.
  - MEM match with MEM.mr=1 -> hazard (load data not yet in MEM/WB); sel 00.
  - MEM match with MEM.mr=0 -> sel 10.
  - WB match -> sel 01.
  - Otherwise -> sel 00.
  - Priority is EX > MEM > WB. The youngest producer wins.
- stall = hazard(rs) | hazard(rt). During a stall the sels still reflect the evaluation above, but downstream ignores them.
- Resulting stall lengths, with no extra FSM state needed:
  - ALU producer in EX: 1 cycle, then sel=10.
  - Load in EX: 2 cycles, then sel=01.
  - Load in MEM: 1 cycle, then sel=01.
- Both operands can match different stages; each sel is evaluated independently. Example: rs=10 and rt=01 is legal.
- Both operands equal (rs==rt): both sels are identical.
- stall_cnt increments by 1 on every clk edge where stall=1. It saturates at all-ones and never wraps.
- Reset (async, rst_n=0):
  - All shadow s_v=0, s_rw=0, s_mr=0, s_dst=0.
  - stall_cnt=0.
  - Outputs therefore immediately become sel_rs=sel_rt=00 and stall=0.
  - Reset mid-stall discards the in-flight hazard. The first post-reset branch sees empty stages.
- Deassertion of rst_n is synchronised externally; the block only requires async assert.
- Non-branch ID instructions never cause a stall from this block. EX-stage ALU forwarding is a separate unit.

Decomposition:
- Shared package:
  - SEL_RF=2'b00, SEL_MEMWB=2'b01, SEL_EXMEM=2'b10.
  - REG_AW default.
  - A shadow-stage struct {v, rw, mr, dst}.
- One natural sub-module, branch_fwd_decode. It is purely combinational: one operand plus three shadow stages in, {sel, hazard} out. It is instantiated twice, once for rs and once for rt.
- The top holds the shadow pipeline registers, the stall OR and the counter.

Test Plan:
- Reset then idle: rst_n low mid-run with stall_cnt=5 -> immediately sel_rs=sel_rt=00, stall=0, stall_cnt=0.
- ALU producer: add $8 issued, then next cycle beq $8,$9 -> cycle 1: stall=1. Cycle 2: stall=0, sel_rs=10, sel_rt=00. stall_cnt=1.
- Load-use: lw $8 issued, then next cycle beq $9,$8 -> stall=1 for 2 cycles. Then sel_rt=01, sel_rs=00. stall_cnt=2.
- Gap of one: lw $8, nop, beq $8,$8 -> 1 stall cycle, then sel_rs=sel_rt=01.
- Priority and zero register:
  - add $8, add $8, beq $8,$0 -> 1 stall, then sel_rs=10, not 01; sel_rt=00 throughout.
  - addi $0 producer -> no stall.
- Counter saturation: CNT_W=4 with 20 stall cycles forced -> stall_cnt holds 15.
